// File: rtl/cpu_pkg.sv
// Types and constants shared across the CPU front end.
// word_align() clears the byte-offset bits of a byte address.
package cpu_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    FLUSH = 2'd3
  } if_state_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return a & ~{{(XLEN-2){1'b0}}, 2'b11};
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-side bundle: ROM port, decode handshake, redirect input and debug outputs.
// master = fetch unit, slave = ROM/decode/execute environment.
interface inst_fetch_if;
  import cpu_pkg::*;

  logic [XLEN-1:0] rom_addr;
  logic [XLEN-1:0] rom_inst;
  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_inst;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_pc4;
  logic            redir_valid;
  logic [XLEN-1:0] redir_pc;
  logic            misalign;
  logic [XLEN-1:0] fetch_cnt;

  modport master (
    output rom_addr, if_valid, if_inst, if_pc, if_pc4, misalign, fetch_cnt,
    input  rom_inst, if_ready, redir_valid, redir_pc
  );

  modport slave (
    input  rom_addr, if_valid, if_inst, if_pc, if_pc4, misalign, fetch_cnt,
    output rom_inst, if_ready, redir_valid, redir_pc
  );

endinterface

// File: rtl/inst_fetch_pc_reg.sv
// Program counter: word-aligned reset value, hold, +4 increment, redirect load.
module pc_reg
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inc_i,
  input  logic            redir_i,
  input  logic [XLEN-1:0] target_i,
  output logic [XLEN-1:0] pc_o
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;

  // Redirect beats increment; otherwise hold.
  always_comb begin
    pc_d = pc_q;
    if (redir_i) begin
      pc_d = word_align(target_i);
    end else if (inc_i) begin
      pc_d = pc_q + 32'd4;
    end else begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= word_align(RESET_PC);
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch front end: fetch FSM, registered fetch slot toward decode,
// redirect handling, sticky misalign flag and retired-fetch counter.
module inst_fetch
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  inst_fetch_if.master bus
);

  if_state_t       state_q, state_d;
  logic [XLEN-1:0] pc;
  logic            if_valid_q;
  logic [XLEN-1:0] if_inst_q, if_pc_q, if_pc4_q;
  logic            misalign_q;
  logic [XLEN-1:0] fetch_cnt_q;
  logic            fetching;
  logic            xfer;
  logic            load;

  // BOOT and FLUSH are bubble states; only RUN/STALL may fill the slot.
  assign fetching = (state_q == RUN) || (state_q == STALL);
  assign xfer     = if_valid_q && bus.if_ready;
  assign load     = fetching && (!if_valid_q || bus.if_ready) && !bus.redir_valid;

  always_comb begin
    state_d = state_q;
    if (bus.redir_valid) begin
      state_d = FLUSH;
    end else begin
      case (state_q)
        BOOT:    state_d = RUN;
        RUN:     state_d = (if_valid_q && !bus.if_ready) ? STALL : RUN;
        STALL:   state_d = bus.if_ready ? RUN : STALL;
        FLUSH:   state_d = RUN;
        default: state_d = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk      (clk),
    .rst      (rst),
    .inc_i    (load),
    .redir_i  (bus.redir_valid),
    .target_i (bus.redir_pc),
    .pc_o     (pc)
  );

  // A redirect discards the slot even when stalled; contents are simply left stale.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_valid_q <= 1'b0;
      if_inst_q  <= INST_NOP;
      if_pc_q    <= 32'h0000_0000;
      if_pc4_q   <= 32'h0000_0000;
    end else if (bus.redir_valid) begin
      if_valid_q <= 1'b0;
    end else if (load) begin
      if_valid_q <= 1'b1;
      if_inst_q  <= bus.rom_inst;
      if_pc_q    <= pc;
      if_pc4_q   <= pc + 32'd4;
    end else if (xfer) begin
      if_valid_q <= 1'b0;
    end
  end

  // A transfer coinciding with a redirect still counts as retired.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= 32'h0000_0000;
      misalign_q  <= 1'b0;
    end else begin
      if (xfer) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (bus.redir_valid && (bus.redir_pc[1:0] != 2'b00)) begin
        misalign_q <= 1'b1;
      end
    end
  end

  assign bus.rom_addr  = {2'b00, pc[XLEN-1:2]};
  assign bus.if_valid  = if_valid_q;
  assign bus.if_inst   = if_inst_q;
  assign bus.if_pc     = if_pc_q;
  assign bus.if_pc4    = if_pc4_q;
  assign bus.misalign  = misalign_q;
  assign bus.fetch_cnt = fetch_cnt_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: cycle table on a RESET_PC=0 instance, and a
// scoreboard of expected slot contents on a RESET_PC=0xFFFF_FFF8 instance.
module tb_inst_fetch;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic clk = 1'b0;
  logic rst0, rst1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  inst_fetch_if bus0();
  inst_fetch_if bus1();

  inst_fetch #(.RESET_PC(32'h0000_0000)) dut0 (.clk(clk), .rst(rst0), .bus(bus0));
  inst_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut1 (.clk(clk), .rst(rst1), .bus(bus1));

  // ROM word k holds BASE + k.
  assign bus0.rom_inst = BASE + bus0.rom_addr;
  assign bus1.rom_inst = BASE + bus1.rom_addr;

  typedef struct {
    logic        rst, rdy, rv;
    logic [31:0] rpc;
    logic        chk;
    logic        ev;
    logic [31:0] ei, epc, epc4, era;
    logic        em;
    logic [31:0] ecnt;
  } vec_t;

  typedef struct {
    logic [31:0] pc, inst, pc4;
  } slot_t;

  vec_t  tbl[$];
  slot_t sb_q[$];
  logic  sb_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t v(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc,
                             input logic chk, input logic ev, input logic [31:0] ei,
                             input logic [31:0] epc, input logic [31:0] epc4, input logic [31:0] era,
                             input logic em, input logic [31:0] ecnt);
    vec_t t;
    t.rst = r; t.rdy = rdy; t.rv = rv; t.rpc = rpc; t.chk = chk; t.ev = ev;
    t.ei = ei; t.epc = epc; t.epc4 = epc4; t.era = era; t.em = em; t.ecnt = ecnt;
    return t;
  endfunction

  // Scoreboard monitor: each handshake on dut1 retires the oldest expected slot.
  always @(negedge clk) begin
    if (sb_on && bus1.if_valid && bus1.if_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_xfer", bus1.if_pc, 32'hDEAD_BEEF);
      end else begin
        slot_t e;
        e = sb_q.pop_front();
        check("sb_if_pc", bus1.if_pc, e.pc);
        check("sb_if_inst", bus1.if_inst, e.inst);
        check("sb_if_pc4", bus1.if_pc4, e.pc4);
      end
    end
  end

  initial begin
    slot_t s;
    // rst rdy rv rpc | chk ev inst pc pc4 rom_addr mis cnt
    tbl.push_back(v(1,1,0,0, 1,0,0,0,0,0,0,0));
    tbl.push_back(v(1,1,0,0, 1,0,0,0,0,0,0,0));
    tbl.push_back(v(0,1,0,0, 1,0,0,0,0,0,0,0));                       // BOOT bubble
    tbl.push_back(v(0,1,0,0, 1,1,BASE+0,32'h0,32'h4,32'h1,0,0));
    tbl.push_back(v(0,1,0,0, 1,1,BASE+1,32'h4,32'h8,32'h2,0,1));
    tbl.push_back(v(0,1,0,0, 1,1,BASE+2,32'h8,32'hC,32'h3,0,2));
    tbl.push_back(v(0,0,0,0, 1,1,BASE+2,32'h8,32'hC,32'h3,0,2));       // stall x3
    tbl.push_back(v(0,0,0,0, 1,1,BASE+2,32'h8,32'hC,32'h3,0,2));
    tbl.push_back(v(0,0,0,0, 1,1,BASE+2,32'h8,32'hC,32'h3,0,2));
    tbl.push_back(v(0,1,0,0, 1,1,BASE+3,32'hC,32'h10,32'h4,0,3));
    tbl.push_back(v(0,1,1,32'h40, 0,0,0,0,0,32'h10,0,4));              // redirect + transfer
    tbl.push_back(v(0,1,0,0, 0,0,0,0,0,32'h10,0,4));
    tbl.push_back(v(0,1,0,0, 1,1,BASE+32'h10,32'h40,32'h44,32'h11,0,4));
    tbl.push_back(v(0,1,0,0, 1,1,BASE+32'h11,32'h44,32'h48,32'h12,0,5));
    tbl.push_back(v(0,0,0,0, 1,1,BASE+32'h11,32'h44,32'h48,32'h12,0,5));
    tbl.push_back(v(0,0,1,32'h22, 0,0,0,0,0,32'h8,1,5));               // misaligned redirect in stall
    tbl.push_back(v(0,0,0,0, 0,0,0,0,0,32'h8,1,5));
    tbl.push_back(v(0,0,0,0, 1,1,BASE+8,32'h20,32'h24,32'h9,1,5));
    tbl.push_back(v(0,1,0,0, 1,1,BASE+9,32'h24,32'h28,32'hA,1,6));
    tbl.push_back(v(0,1,0,0, 1,1,BASE+32'hA,32'h28,32'h2C,32'hB,1,7));
    tbl.push_back(v(0,0,0,0, 1,1,BASE+32'hA,32'h28,32'h2C,32'hB,1,7));
    tbl.push_back(v(1,0,0,0, 1,0,0,0,0,0,0,0));                       // reset mid-stall
    tbl.push_back(v(0,1,0,0, 1,0,0,0,0,0,0,0));
    tbl.push_back(v(0,1,0,0, 1,1,BASE+0,32'h0,32'h4,32'h1,0,0));
    tbl.push_back(v(0,1,0,0, 1,1,BASE+1,32'h4,32'h8,32'h2,0,1));

    rst1 = 1'b1;
    bus1.if_ready = 1'b1; bus1.redir_valid = 1'b0; bus1.redir_pc = 32'h0;
    rst0 = tbl[0].rst; bus0.if_ready = tbl[0].rdy;
    bus0.redir_valid = tbl[0].rv; bus0.redir_pc = tbl[0].rpc;

    foreach (tbl[i]) begin
      rst0 = tbl[i].rst; bus0.if_ready = tbl[i].rdy;
      bus0.redir_valid = tbl[i].rv; bus0.redir_pc = tbl[i].rpc;
      @(posedge clk); #1;
      check($sformatf("row%0d_valid", i), {31'b0, bus0.if_valid}, {31'b0, tbl[i].ev});
      check($sformatf("row%0d_rom_addr", i), bus0.rom_addr, tbl[i].era);
      check($sformatf("row%0d_misalign", i), {31'b0, bus0.misalign}, {31'b0, tbl[i].em});
      check($sformatf("row%0d_fetch_cnt", i), bus0.fetch_cnt, tbl[i].ecnt);
      if (tbl[i].chk) begin
        check($sformatf("row%0d_if_inst", i), bus0.if_inst, tbl[i].ei);
        check($sformatf("row%0d_if_pc", i), bus0.if_pc, tbl[i].epc);
        check($sformatf("row%0d_if_pc4", i), bus0.if_pc4, tbl[i].epc4);
      end
    end
    bus0.redir_valid = 1'b0;

    // Wrap-around instance: reset values, then expected slots via scoreboard.
    check("wrap_reset_rom_addr", bus1.rom_addr, 32'h3FFF_FFFE);
    check("wrap_reset_valid", {31'b0, bus1.if_valid}, 32'h0);
    s.pc = 32'hFFFF_FFF8; s.inst = 32'h4FFF_FFFE; s.pc4 = 32'hFFFF_FFFC; sb_q.push_back(s);
    s.pc = 32'hFFFF_FFFC; s.inst = 32'h4FFF_FFFF; s.pc4 = 32'h0000_0000; sb_q.push_back(s);
    s.pc = 32'h0000_0000; s.inst = BASE;          s.pc4 = 32'h0000_0004; sb_q.push_back(s);
    s.pc = 32'h0000_0004; s.inst = BASE + 32'd1;  s.pc4 = 32'h0000_0008; sb_q.push_back(s);
    sb_on = 1'b1;
    rst1 = 1'b0;
    for (int c = 0; c < 30 && sb_q.size() != 0; c++) begin
      @(posedge clk); #1;
    end
    check("wrap_sb_drained", sb_q.size(), 32'd0);
    sb_on = 1'b0;
    check("wrap_fetch_cnt", bus1.fetch_cnt, 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
